// File: rtl/mult_block_pkg.sv
// Shared constants and types for the multiplier and divider blocks.
package mult_block_pkg;

  localparam int unsigned MULT_A_W   = 32;
  localparam int unsigned MULT_B_W   = 32;
  localparam int unsigned MULT_P_W   = MULT_A_W + MULT_B_W;

  localparam int unsigned DIV_DEFAULT_DIVISOR = 7733;
  localparam int unsigned DIV_STEPS           = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/divider_block_7733_div_step.sv
// One restoring shift-subtract division step; pure combinational.
module div_step (
  input  logic [32:0] r,
  input  logic        d_bit,
  input  logic [31:0] divisor,
  output logic [32:0] r_next,
  output logic        q_bit
);

  // One extra bit above the 33-bit remainder so the shifted value never wraps.
  logic [33:0] wide;

  always_comb begin
    wide   = {r, d_bit};
    q_bit  = (wide >= {2'b00, divisor});
    r_next = q_bit ? 33'(wide - {2'b00, divisor}) : wide[32:0];
  end

endmodule

// File: rtl/divider_block_7733.sv
// Iterative 32-cycle unsigned divider by a constant DIVISOR.
// Build with DIV7733_REM_EN defined to expose the remainder on o_rem.
module divider_block_7733
  import mult_block_pkg::*;
#(
  parameter int unsigned DIVISOR = DIV_DEFAULT_DIVISOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_data0,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o_data0
`ifdef DIV7733_REM_EN
  ,
  output logic [31:0] o_rem
`endif
);

  localparam logic [31:0] DIV_W  = 32'(DIVISOR);
  localparam logic [4:0]  CNT_HI = 5'(DIV_STEPS - 1);

  div_state_e  state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] dvd;
  logic [31:0] quot;
  logic [32:0] rem_q;
  logic [32:0] r_next;
  logic        q_bit;

  div_step u_step (
    .r      (rem_q),
    .d_bit  (dvd[cnt]),
    .divisor(DIV_W),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid)      state_nxt = BUSY;
      BUSY:    if (cnt == 5'd0)  state_nxt = DONE;
      DONE:    if (o_ready)      state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode the registered state only.
  assign i_ready = (state == IDLE);
  assign o_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 5'd0;
      dvd   <= 32'd0;
      quot  <= 32'd0;
      rem_q <= 33'd0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          dvd   <= i_data0;
          quot  <= 32'd0;
          rem_q <= 33'd0;
          cnt   <= CNT_HI;
        end
        BUSY: begin
          rem_q <= r_next;
          quot  <= {quot[30:0], q_bit};
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_data0 = quot;
`ifdef DIV7733_REM_EN
  assign o_rem = rem_q[31:0];
`endif

endmodule

// File: tb/tb_divider_block_7733.sv
// Randomized bench for divider_block_7733 against a plain-arithmetic model.
module tb_divider_block_7733;

  localparam int unsigned DIV = 7733;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_data0;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data0;
`ifdef DIV7733_REM_EN
  logic [31:0] o_rem;
`endif

  int n_cmp = 0;
  int n_err = 0;

  divider_block_7733 #(.DIVISOR(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .i_data0(i_data0),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_data0(o_data0)
`ifdef DIV7733_REM_EN
    ,
    .o_rem  (o_rem)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cur_rem();
`ifdef DIV7733_REM_EN
    return o_rem;
`else
    return 32'd0;
`endif
  endfunction

  // Sends one dividend, checks latency/busy/backpressure, returns the result.
  task automatic do_op(input logic [31:0] d, input int hold, input bit strict,
                       output logic [31:0] q, output logic [31:0] r);
    int n;
    int w;
    bit busy_ok;
    w = 0;
    @(negedge clk);
    while (!i_ready && w < 100) begin @(negedge clk); w++; end
    if (strict || !i_ready) chk("accept_ready", {63'd0, i_ready}, 64'd1);
    i_valid = 1'b1;
    i_data0 = d;
    @(posedge clk);
    n = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    i_valid = 1'($urandom_range(0, 1));
    i_data0 = $urandom;
    while (!o_valid && n < 200) begin
      if (i_ready) busy_ok = 1'b0;
      o_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      n++;
      @(negedge clk);
      i_valid = 1'($urandom_range(0, 1));
      i_data0 = $urandom;
    end
    o_ready = (hold == 0);
    if (strict || n != 32) chk("latency", 64'(n), 64'd32);
    if (strict || !busy_ok) chk("busy_i_ready_low", {63'd0, busy_ok}, 64'd1);
    q = o_data0;
    r = cur_rem();
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (strict || o_data0 !== q || !o_valid || i_ready) begin
        chk("hold_q", 64'(o_data0), 64'(q));
        chk("hold_vld", {63'd0, o_valid}, 64'd1);
        chk("hold_i_ready", {63'd0, i_ready}, 64'd0);
`ifdef DIV7733_REM_EN
        chk("hold_r", 64'(o_rem), 64'(r));
`endif
      end
      i_valid = 1'($urandom_range(0, 1));
    end
    o_ready = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    o_ready = 1'b0;
    if (strict || !i_ready || o_valid) begin
      chk("release_i_ready", {63'd0, i_ready}, 64'd1);
      chk("release_o_valid", {63'd0, o_valid}, 64'd0);
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] d,
                           input logic [31:0] q, input logic [31:0] r);
    logic [31:0] eq;
    logic [31:0] er;
    eq = d / DIV;
    er = d % DIV;
    chk({tag, "_q"}, 64'(q), 64'(eq));
`ifdef DIV7733_REM_EN
    chk({tag, "_r"}, 64'(r), 64'(er));
    chk({tag, "_id"}, 64'(q) * 64'(DIV) + 64'(r), 64'(d));
`else
    if (r != 32'd0) chk({tag, "_r0"}, 64'(r), 64'd0);
`endif
  endtask

  initial begin
    logic [31:0] q, r, d;
    bit vld_seen;
    int nbad;
    rst = 1'b1;
    i_valid = 1'b0;
    i_data0 = 32'd0;
    o_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_ready", {63'd0, i_ready}, 64'd1);
    chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_o_data0", 64'(o_data0), 64'd0);
`ifdef DIV7733_REM_EN
    chk("rst_o_rem", 64'(o_rem), 64'd0);
`endif
    rst = 1'b0;

    do_op(32'd7733000, 0, 1'b1, q, r);
    check_res("d7733000", 32'd7733000, q, r);
    chk("d7733000_q_const", 64'(q), 64'd1000);

    do_op(32'hFFFF_FFFF, 1, 1'b1, q, r);
    check_res("dmax", 32'hFFFF_FFFF, q, r);
    chk("dmax_q_const", 64'(q), 64'd555407);
`ifdef DIV7733_REM_EN
    chk("dmax_r_const", 64'(r), 64'd4964);
`endif

    do_op(32'd0, 0, 1'b1, q, r);
    check_res("d0", 32'd0, q, r);
    do_op(32'd7732, 0, 1'b1, q, r);
    check_res("d7732", 32'd7732, q, r);
    do_op(32'd7733, 0, 1'b1, q, r);
    check_res("d7733", 32'd7733, q, r);

    do_op(32'd100, 10, 1'b1, q, r);
    check_res("bp10", 32'd100, q, r);

    // Reset mid-computation: the aborted result must never surface.
    @(negedge clk);
    i_valid = 1'b1;
    i_data0 = 32'd123456;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    o_ready = 1'b1;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    chk("abort_i_ready", {63'd0, i_ready}, 64'd1);
    chk("abort_o_data0", 64'(o_data0), 64'd0);
    vld_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid) vld_seen = 1'b1;
    end
    chk("abort_no_vld", {63'd0, vld_seen}, 64'd0);
    do_op(32'd15466, 0, 1'b1, q, r);
    check_res("d15466", 32'd15466, q, r);
    chk("d15466_q_const", 64'(q), 64'd2);

    nbad = n_err;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0:       d = $urandom_range(0, DIV - 1);
        1:       d = DIV * $urandom_range(0, 555407);
        default: d = $urandom;
      endcase
      do_op(d, $urandom_range(0, 3), 1'b0, q, r);
      if (q != d / DIV || cur_rem() != 32'd0 && 0) ;
      check_res("rand", d, q, r);
`ifdef DIV7733_REM_EN
      if (r >= DIV) chk("rand_r_lt", 64'(r), 64'(d % DIV));
`endif
      if (n_err - nbad > 20) break;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/divider_block_7733.md
DIVIDER_BLOCK_7733 -- requirements
Module: divider_block_7733

Interface
REQ-001 SHALL have parameter DIVISOR, default 7733, constant unsigned divisor; legal range 1..2^31-1.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have i_valid  input  1  dividend offered.
REQ-005 SHALL have i_ready  output  1  block can accept a dividend.
REQ-006 SHALL have i_data0  input  32  unsigned dividend.
REQ-007 SHALL have o_valid  output  1  result available.
REQ-008 SHALL have o_ready  input  1  consumer takes result.
REQ-009 SHALL have o_data0  output  32  unsigned quotient floor(i_data0/DIVISOR).
REQ-010 SHALL have o_rem  output  32  remainder i_data0 mod DIVISOR; present only with DIV7733_REM_EN.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-012 SHALL drive i_ready=1 only in IDLE and o_valid=1 only in DONE; both are registered-state decodes, with no combinational path from i_valid or o_ready.
REQ-013 SHALL, in IDLE on i_valid&&i_ready at edge T, latch i_data0, clear the partial remainder, load bit counter to 31, and enter BUSY.
REQ-014 SHALL, in BUSY, perform one restoring shift-subtract step per cycle, MSB first: r=(r<<1)|d[k]; if r>=DIVISOR then r-=DIVISOR and q[k]=1, else q[k]=0.
REQ-015 SHALL use a 33-bit partial remainder internally so the compare never overflows.
REQ-016 SHALL enter DONE at edge T+32 after exactly 32 steps, giving o_valid high in the cycle after edge T+32 (fixed latency, data independent).
REQ-017 SHALL hold o_data0/o_rem stable while o_valid=1 and o_ready=0 (backpressure, unlimited duration).
REQ-018 SHALL return to IDLE on o_valid&&o_ready; i_ready rises the following cycle, with no same-cycle accept in DONE.
REQ-019 SHALL ignore i_valid and i_data0 in BUSY and DONE, and ignore o_ready outside DONE.
REQ-020 SHALL produce, for dividend 0, quotient 0 and remainder 0; for dividend < DIVISOR, quotient 0 and remainder equal to the dividend.

Reset
REQ-021 SHALL on rst=1 force IDLE, with i_ready=1 the cycle after, o_valid=0, o_data0=0, o_rem=0, and counter=0.
REQ-022 SHALL abort any in-flight BUSY or DONE operation on rst with no output handshake, and the aborted result SHALL never appear.
REQ-023 SHALL give rst priority over every handshake in the same cycle.

Configuration
REQ-024 SHALL, when macro DIV7733_REM_EN is defined, expose o_rem carrying the final remainder.
REQ-025 SHALL, when DIV7733_REM_EN is undefined, omit o_rem; quotient behaviour and timing SHALL be identical.

Structure
REQ-026 SHALL place the FSM state enum, the default divisor constant (7733), and the step count constant (32) in shared package mult_block_pkg, alongside the multiplier block constants.
REQ-027 SHALL keep the single shift-subtract step as combinational sub-module div_step (inputs r, dividend bit, divisor; outputs next r, quotient bit), instantiated once.

Verification
REQ-028 SHALL cover: send 7733000 -> o_data0=1000, o_rem=0, with o_valid rising exactly 32 edges after the accept edge.
REQ-029 SHALL cover: send 0xFFFFFFFF -> o_data0=555407, o_rem=4964.
REQ-030 SHALL cover: send 7732, then 7733 -> first result q=0/r=7732, second q=1/r=0; i_ready=0 throughout BUSY and DONE.
REQ-031 SHALL cover: hold o_ready=0 for 10 cycles after o_valid -> outputs stable, i_ready stays 0; release -> i_ready=1 next cycle.
REQ-032 SHALL cover: assert rst at step 15 of BUSY with dividend 123456 -> o_valid never rises; next dividend 15466 -> q=2, r=0.
REQ-033 SHALL cover: a self-check loop, for 1000 random dividends with random o_ready, of q*7733+r == dividend (mod 2^32 not needed) and r<7733, in both DIV7733_REM_EN builds.
